bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Shares one registered memory port between the instruction-fetch side and
// the load/store (MEM) side of a pipeline. Data requests have fixed priority
// over instruction requests. Each access holds the bus until the slave acks
// or a wait-cycle limit expires. It then spends one RESP cycle pulsing the
// granted side's ready (and err on a timeout) before returning to IDLE.
//
// Ports
//   clk_i, rst_i                    clock, asynchronous active-low reset
//   inst_req_i, inst_addr_i         fetch request / word address
//   inst_rdata_o, inst_ready_o      fetched word / one-cycle completion
//   data_req_i, data_we_i,
//   data_sel_i, data_addr_i,
//   data_wdata_i                    load/store request from MEM
//   data_rdata_o, data_ready_o      load data / one-cycle completion
//   bus_req_o, bus_we_o, bus_sel_o,
//   bus_addr_o, bus_wdata_o         registered shared memory port
//   bus_ack_i, bus_rdata_i          slave completion / read data
//   stall_if_o, stall_mem_o         pipeline stall requests
//   err_o                           timeout pulse, concurrent with ready
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_rdata_o,
  output logic        inst_ready_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_sel_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  // Count value at which an un-acked access gives up.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_waitCnt;
  logic        w_timeout;
  logic        r_busReq;
  logic        r_busWe;
  logic [3:0]  r_busSel;
  logic [31:0] r_busAddr;
  logic [31:0] r_busWdata;
  logic [31:0] r_instRdata;
  logic [31:0] r_dataRdata;
  logic        r_instReady;
  logic        r_dataReady;
  logic        r_err;

  assign w_timeout = (r_waitCnt == TimeoutLast);

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. An ack arriving together with the timeout still
  // counts as a normal completion; that distinction is made in the datapath.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (data_req_i) begin
          w_next = DATA;
        end else if (inst_req_i) begin
          w_next = INST;
        end
      end
      INST, DATA: begin
        if (bus_ack_i || w_timeout) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus port, wait counter and response registers. The bus fields are
  // latched at grant time so the slave sees stable values even if the
  // requester withdraws (pipeline flush) mid-access. A store that ends
  // without an ack leaves data_rdata_o untouched, since a store has no
  // read data to replace.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_waitCnt   <= 8'd0;
      r_busReq    <= 1'b0;
      r_busWe     <= 1'b0;
      r_busSel    <= 4'd0;
      r_busAddr   <= 32'd0;
      r_busWdata  <= 32'd0;
      r_instRdata <= 32'd0;
      r_dataRdata <= 32'd0;
      r_instReady <= 1'b0;
      r_dataReady <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_instReady <= 1'b0;
      r_dataReady <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        IDLE: begin
          r_waitCnt <= 8'd0;
          if (data_req_i) begin
            r_busReq   <= 1'b1;
            r_busWe    <= data_we_i;
            r_busSel   <= data_sel_i;
            r_busAddr  <= data_addr_i;
            r_busWdata <= data_wdata_i;
          end else if (inst_req_i) begin
            r_busReq   <= 1'b1;
            r_busWe    <= 1'b0;
            r_busSel   <= 4'b1111;
            r_busAddr  <= inst_addr_i;
            r_busWdata <= 32'd0;
          end
        end
        INST: begin
          if (bus_ack_i) begin
            r_busReq    <= 1'b0;
            r_instRdata <= bus_rdata_i;
            r_instReady <= 1'b1;
          end else if (w_timeout) begin
            r_busReq    <= 1'b0;
            r_instRdata <= 32'd0;
            r_instReady <= 1'b1;
            r_err       <= 1'b1;
          end else if (r_waitCnt != 8'hFF) begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        DATA: begin
          if (bus_ack_i) begin
            r_busReq    <= 1'b0;
            r_dataReady <= 1'b1;
            if (!r_busWe) begin
              r_dataRdata <= bus_rdata_i;
            end
          end else if (w_timeout) begin
            r_busReq    <= 1'b0;
            r_dataReady <= 1'b1;
            r_err       <= 1'b1;
            if (!r_busWe) begin
              r_dataRdata <= 32'd0;
            end
          end else if (r_waitCnt != 8'hFF) begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus_req_o    = r_busReq;
  assign bus_we_o     = r_busWe;
  assign bus_sel_o    = r_busSel;
  assign bus_addr_o   = r_busAddr;
  assign bus_wdata_o  = r_busWdata;
  assign inst_rdata_o = r_instRdata;
  assign data_rdata_o = r_dataRdata;
  assign inst_ready_o = r_instReady;
  assign data_ready_o = r_dataReady;
  assign err_o        = r_err;

  // Stalls are gated by reset so every output reads 0 while rst_i is low.
  assign stall_if_o  = rst_i & inst_req_i & ~r_instReady;
  assign stall_mem_o = rst_i & data_req_i & ~r_dataReady;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Drives two arbiters from the same inputs: u_dut with the default timeout
// and u_dut4 with TIMEOUT_CYCLES=4 for the timeout corner cases. Normal
// transfers come from a vector table; expected responses are queued when a
// request is driven and popped by a monitor when a ready pulse appears.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        instReq;
  logic [31:0] instAddr;
  logic        dataReq;
  logic        dataWe;
  logic [3:0]  dataSel;
  logic [31:0] dataAddr;
  logic [31:0] dataWdata;
  logic        busAck;
  logic [31:0] busRdata;

  logic [31:0] instRdata, dataRdata, busAddr, busWdata;
  logic        instReady, dataReady, busReq, busWe, stallIf, stallMem, err;
  logic [3:0]  busSel;

  logic [31:0] tInstRdata, tDataRdata, tBusAddr, tBusWdata;
  logic        tInstReady, tDataReady, tBusReq, tBusWe, tStallIf, tStallMem, tErr;
  logic [3:0]  tBusSel;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        isData;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ackDelay;
    logic [31:0] busRdata;
    logic [31:0] expRdata;
  } vec_t;

  typedef struct {
    logic        isData;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[5];
  exp_t expQ[$];

  bus_arbiter u_dut (
    .clk_i(clk), .rst_i(rstN),
    .inst_req_i(instReq), .inst_addr_i(instAddr),
    .inst_rdata_o(instRdata), .inst_ready_o(instReady),
    .data_req_i(dataReq), .data_we_i(dataWe), .data_sel_i(dataSel),
    .data_addr_i(dataAddr), .data_wdata_i(dataWdata),
    .data_rdata_o(dataRdata), .data_ready_o(dataReady),
    .bus_req_o(busReq), .bus_we_o(busWe), .bus_sel_o(busSel),
    .bus_addr_o(busAddr), .bus_wdata_o(busWdata),
    .bus_ack_i(busAck), .bus_rdata_i(busRdata),
    .stall_if_o(stallIf), .stall_mem_o(stallMem), .err_o(err)
  );

  bus_arbiter #(.TIMEOUT_CYCLES(4)) u_dut4 (
    .clk_i(clk), .rst_i(rstN),
    .inst_req_i(instReq), .inst_addr_i(instAddr),
    .inst_rdata_o(tInstRdata), .inst_ready_o(tInstReady),
    .data_req_i(dataReq), .data_we_i(dataWe), .data_sel_i(dataSel),
    .data_addr_i(dataAddr), .data_wdata_i(dataWdata),
    .data_rdata_o(tDataRdata), .data_ready_o(tDataReady),
    .bus_req_o(tBusReq), .bus_we_o(tBusWe), .bus_sel_o(tBusSel),
    .bus_addr_o(tBusAddr), .bus_wdata_o(tBusWdata),
    .bus_ack_i(busAck), .bus_rdata_i(busRdata),
    .stall_if_o(tStallIf), .stall_mem_o(tStallMem), .err_o(tErr)
  );

  always #5 clk = ~clk;

  // One comparison; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each ready pulse of u_dut must match the oldest
  // expected response.
  always @(negedge clk) begin
    if (rstN && (instReady || dataReady)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_ready", {30'd0, dataReady, instReady}, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sb_side", {30'd0, dataReady, instReady}, e.isData ? 32'd2 : 32'd1);
        checkOutput("sb_rdata", e.isData ? dataRdata : instRdata, e.rdata);
        checkOutput("sb_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  // Drives one table transfer, starting at a negedge with u_dut in IDLE,
  // and plays the slave with the vector's ack delay.
  task automatic applyStimulus(input vec_t v);
    logic [31:0] expAddr;
    expAddr   = v.addr;
    instReq   = !v.isData;
    dataReq   = v.isData;
    instAddr  = v.isData ? 32'hFFFF_0000 : v.addr;
    dataAddr  = v.isData ? v.addr : 32'hEEEE_0000;
    dataWe    = v.we;
    dataSel   = v.sel;
    dataWdata = v.wdata;
    expQ.push_back('{v.isData, v.expRdata, 1'b0});
    #1;
    checkOutput("stall_c0", {31'd0, v.isData ? stallMem : stallIf}, 32'd1);
    @(negedge clk);
    checkOutput("bus_req_c1", {31'd0, busReq}, 32'd1);
    checkOutput("bus_addr", busAddr, expAddr);
    checkOutput("bus_we", {31'd0, busWe}, {31'd0, v.isData ? v.we : 1'b0});
    checkOutput("bus_sel", {28'd0, busSel}, {28'd0, v.isData ? v.sel : 4'hF});
    checkOutput("bus_wdata", busWdata, v.isData ? v.wdata : 32'd0);
    checkOutput("stall_c1", {31'd0, v.isData ? stallMem : stallIf}, 32'd1);
    for (int i = 0; i < v.ackDelay; i++) begin
      @(negedge clk);
      checkOutput("bus_req_wait", {31'd0, busReq}, 32'd1);
      checkOutput("bus_addr_wait", busAddr, expAddr);
    end
    busAck   = 1'b1;
    busRdata = v.busRdata;
    @(negedge clk);
    busAck   = 1'b0;
    checkOutput("ready_resp", {30'd0, dataReady, instReady}, v.isData ? 32'd2 : 32'd1);
    checkOutput("bus_req_resp", {31'd0, busReq}, 32'd0);
    checkOutput("stall_resp", {31'd0, v.isData ? stallMem : stallIf}, 32'd0);
    instReq = 1'b0;
    dataReq = 1'b0;
    @(negedge clk);
    checkOutput("ready_idle", {30'd0, dataReady, instReady}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; instReq = 1'b0; instAddr = '0; dataReq = 1'b0; dataWe = 1'b0;
    dataSel = '0; dataAddr = '0; dataWdata = '0; busAck = 1'b0; busRdata = '0;

    vecs[0] = '{1'b0, 1'b1, 4'h3, 32'h0000_0040, 32'h55, 0, 32'h2401_0005, 32'h2401_0005};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0,  2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'hA5A5, 0, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 4'h3, 32'h0000_0044, 32'h55, 5, 32'h1111_2222, 32'h1111_2222};
    vecs[4] = '{1'b1, 1'b0, 4'h1, 32'h0000_0208, 32'h0,  1, 32'h0000_00FF, 32'h0000_00FF};

    // Reset state before any clock edge.
    #1;
    checkOutput("rst_bus_req", {31'd0, busReq}, 32'd0);
    checkOutput("rst_ready", {30'd0, dataReady, instReady}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_bus_addr", busAddr, 32'd0);
    checkOutput("rst_inst_rdata", instRdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
    end

    // Simultaneous requests: data store wins, fetch follows after RESP.
    dataReq = 1'b1; dataWe = 1'b1; dataSel = 4'b0011; dataAddr = 32'h100; dataWdata = 32'hA5A5;
    instReq = 1'b1; instAddr = 32'h80;
    expQ.push_back('{1'b1, 32'h0000_00FF, 1'b0});
    expQ.push_back('{1'b0, 32'h0BAD_F00D, 1'b0});
    #1;
    checkOutput("sim_stall_if_c0", {31'd0, stallIf}, 32'd1);
    @(negedge clk);
    checkOutput("sim_bus_we", {31'd0, busWe}, 32'd1);
    checkOutput("sim_bus_sel", {28'd0, busSel}, 32'h3);
    checkOutput("sim_bus_addr", busAddr, 32'h100);
    busAck = 1'b1; busRdata = 32'h7777_7777;
    @(negedge clk);
    busAck = 1'b0;
    checkOutput("sim_data_ready", {30'd0, dataReady, instReady}, 32'd2);
    checkOutput("sim_stall_if_resp", {31'd0, stallIf}, 32'd1);
    dataReq = 1'b0;
    @(negedge clk);
    checkOutput("sim_idle_bus_req", {31'd0, busReq}, 32'd0);
    checkOutput("sim_stall_if_idle", {31'd0, stallIf}, 32'd1);
    @(negedge clk);
    checkOutput("sim_inst_bus_req", {31'd0, busReq}, 32'd1);
    checkOutput("sim_inst_addr", busAddr, 32'h80);
    checkOutput("sim_inst_we", {31'd0, busWe}, 32'd0);
    busAck = 1'b1; busRdata = 32'h0BAD_F00D;
    @(negedge clk);
    busAck = 1'b0;
    checkOutput("sim_inst_ready", {31'd0, instReady}, 32'd1);
    instReq = 1'b0;
    @(negedge clk);

    // Ack while idle is ignored.
    busAck = 1'b1; busRdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_ack_bus_req", {31'd0, busReq}, 32'd0);
    end
    busAck = 1'b0;
    checkOutput("idle_ack_rdata", instRdata, 32'h0BAD_F00D);

    // Fetch withdrawn mid-access still completes.
    instReq = 1'b1; instAddr = 32'h90;
    expQ.push_back('{1'b0, 32'h1357_2468, 1'b0});
    @(negedge clk);
    instReq = 1'b0;
    checkOutput("flush_bus_req_c1", {31'd0, busReq}, 32'd1);
    @(negedge clk);
    checkOutput("flush_bus_req_c2", {31'd0, busReq}, 32'd1);
    busAck = 1'b1; busRdata = 32'h1357_2468;
    @(negedge clk);
    busAck = 1'b0;
    checkOutput("flush_ready", {31'd0, instReady}, 32'd1);
    @(negedge clk);

    // Reset mid-access drops the bus at once; pending fetch served after.
    dataReq = 1'b1; dataWe = 1'b0; dataSel = 4'hF; dataAddr = 32'h300;
    @(negedge clk);
    checkOutput("rstmid_bus_req", {31'd0, busReq}, 32'd1);
    #2;
    rstN = 1'b0; dataReq = 1'b0; instReq = 1'b1; instAddr = 32'hA0;
    #1;
    checkOutput("rstmid_bus_drop", {31'd0, busReq}, 32'd0);
    @(negedge clk);
    checkOutput("rstmid_ready", {30'd0, dataReady, instReady}, 32'd0);
    checkOutput("rstmid_err", {31'd0, err}, 32'd0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_grant", {31'd0, busReq}, 32'd1);
    checkOutput("rstmid_addr", busAddr, 32'hA0);
    expQ.push_back('{1'b0, 32'h600D_CAFE, 1'b0});
    busAck = 1'b1; busRdata = 32'h600D_CAFE;
    @(negedge clk);
    busAck = 1'b0;
    checkOutput("rstmid_inst_ready", {31'd0, instReady}, 32'd1);
    instReq = 1'b0;
    @(negedge clk);

    // TIMEOUT_CYCLES=4: ack on the final wait cycle is a normal completion.
    dataReq = 1'b1; dataWe = 1'b0; dataSel = 4'hF; dataAddr = 32'h404;
    expQ.push_back('{1'b1, 32'hCAFE_F00D, 1'b0});
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkOutput("to_ack_bus_req", {31'd0, tBusReq}, 32'd1);
    end
    @(negedge clk);
    checkOutput("to_ack_bus_req_last", {31'd0, tBusReq}, 32'd1);
    busAck = 1'b1; busRdata = 32'hCAFE_F00D;
    @(negedge clk);
    busAck = 1'b0;
    checkOutput("to_ack_ready", {31'd0, tDataReady}, 32'd1);
    checkOutput("to_ack_err", {31'd0, tErr}, 32'd0);
    checkOutput("to_ack_rdata", tDataRdata, 32'hCAFE_F00D);
    dataReq = 1'b0;
    @(negedge clk);

    // TIMEOUT_CYCLES=4 with no ack: 4 bus cycles, then ready+err, rdata 0.
    dataReq = 1'b1; dataAddr = 32'h400;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput("to_bus_req", {31'd0, tBusReq}, 32'd1);
      checkOutput("to_no_ready", {31'd0, tDataReady}, 32'd0);
    end
    @(negedge clk);
    checkOutput("to_ready", {31'd0, tDataReady}, 32'd1);
    checkOutput("to_err", {31'd0, tErr}, 32'd1);
    checkOutput("to_rdata", tDataRdata, 32'd0);
    checkOutput("to_bus_req_drop", {31'd0, tBusReq}, 32'd0);
    dataReq = 1'b0;
    @(negedge clk);
    checkOutput("to_err_pulse", {31'd0, tErr}, 32'd0);

    // u_dut is still waiting on its 255-cycle limit; reset clears it.
    rstN = 1'b0;
    #1;
    checkOutput("final_rst_bus_req", {31'd0, busReq}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    checkOutput("sb_empty", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
